// File: rtl/spi_master_driver_pkg.sv
// Shared types and constants for the SPI master driver and its shifter.
// Opcodes sit in cmd_word[9:8]; only OP_RD_DATA frames carry a MISO phase.
package spi_master_driver_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        M_IDLE,
        M_START,
        M_SHIFT,
        M_WAIT,
        M_RECV,
        M_END
    } master_state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// Serial datapath: 10-bit shift-out register whose low bits double as the MISO shift-in, plus the phase counter.
// Latency: tx_bit reflects the register MSB; rx_next already includes the MISO bit of the current cycle.
// Backpressure: none; fully steered by the driver FSM.
module spi_master_shifter
    import spi_master_driver_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CMD_W-1:0]  load_word,
    input  logic              shift,
    input  logic              rx_en,
    input  logic              miso,
    input  logic              cnt_load,
    input  logic [3:0]        cnt_init,
    output logic              tx_bit,
    output logic [DATA_W-1:0] rx_next,
    output logic              cnt_zero
);

    logic [CMD_W-1:0] sr;
    logic [3:0]       cnt;

    // Counter loads on phase entry and parks at zero, so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            if (load)
                sr <= load_word;
            else if (shift)
                sr <= {sr[CMD_W-2:0], rx_en ? miso : 1'b0};

            if (cnt_load)
                cnt <= cnt_init;
            else if (cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    assign tx_bit   = sr[CMD_W-1];
    assign rx_next  = {sr[DATA_W-2:0], miso};
    assign cnt_zero = (cnt == 4'd0);

endmodule

// File: rtl/spi_master_driver.sv
// Turns host command words into SPI frames on SS_n/MOSI; read-data frames return a MISO byte on rsp_valid.
// Latency: SS_n falls one cycle after accept; rsp_valid pulses on the first cycle after SS_n rises.
// Backpressure: cmd_ready only in IDLE; rsp_valid has no backpressure.
module spi_master_driver
    import spi_master_driver_pkg::*;
#(
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned GAP_CYC    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_word,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    master_state_e     state;
    logic [1:0]        op;
    logic              accept;
    logic              cnt_load;
    logic [3:0]        cnt_init;
    logic              tx_bit;
    logic [DATA_W-1:0] rx_next;
    logic              cnt_zero;

    assign accept = (state == M_IDLE) && cmd_valid && cmd_ready;

    always_comb begin
        cnt_load = 1'b0;
        cnt_init = 4'd0;
        case (state)
            M_START: begin
                cnt_load = 1'b1;
                cnt_init = 4'(CMD_W - 1);
            end
            M_SHIFT: if (cnt_zero) begin
                cnt_load = 1'b1;
                cnt_init = (op == OP_RD_DATA) ? 4'(TURNAROUND - 1) : 4'(GAP_CYC - 1);
            end
            M_WAIT: if (cnt_zero) begin
                cnt_load = 1'b1;
                cnt_init = 4'(DATA_W - 1);
            end
            M_RECV: if (cnt_zero) begin
                cnt_load = 1'b1;
                cnt_init = 4'(GAP_CYC - 1);
            end
            default: ;
        endcase
    end

    spi_master_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_word (cmd_word),
        .shift     (state == M_START || state == M_SHIFT || state == M_RECV),
        .rx_en     (state == M_RECV),
        .miso      (MISO),
        .cnt_load  (cnt_load),
        .cnt_init  (cnt_init),
        .tx_bit    (tx_bit),
        .rx_next   (rx_next),
        .cnt_zero  (cnt_zero)
    );

    // Outputs are registered alongside the state, so each one reflects the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= M_IDLE;
            op        <= OP_WR_ADDR;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                M_IDLE: begin
                    if (accept) begin
                        state     <= M_START;
                        op        <= cmd_word[CMD_W-1:CMD_W-2];
                        SS_n      <= 1'b0;
                        MOSI      <= cmd_word[CMD_W-1];
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                M_START: state <= M_SHIFT;
                M_SHIFT: begin
                    if (cnt_zero) begin
                        MOSI <= 1'b0;
                        if (op == OP_RD_DATA) begin
                            state <= M_WAIT;
                        end else begin
                            state <= M_END;
                            SS_n  <= 1'b1;
                        end
                    end else begin
                        MOSI <= tx_bit;
                    end
                end
                M_WAIT: if (cnt_zero) state <= M_RECV;
                M_RECV: begin
                    if (cnt_zero) begin
                        state     <= M_END;
                        SS_n      <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= rx_next;
                    end
                end
                M_END: begin
                    if (cnt_zero) begin
                        state     <= M_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= M_IDLE;
                    SS_n      <= 1'b1;
                    MOSI      <= 1'b0;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_driver.sv
// Bench for spi_master_driver: SPI slave/RAM model on the serial side, scoreboard of expected frames.
module tb_spi_master_driver;
    import spi_master_driver_pkg::*;

    localparam int TURN   = 1;
    localparam int GAP    = 1;
    localparam int WR_LEN = CMD_W + 1;
    localparam int RD_LEN = CMD_W + 1 + TURN + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [CMD_W-1:0]  cmd_word = '0;
    logic              MISO = 1'b0;
    logic              cmd_ready, rsp_valid, busy, SS_n, MOSI;
    logic [DATA_W-1:0] rsp_data;

    always #5 clk = ~clk;

    spi_master_driver #(.TURNAROUND(TURN), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_word(cmd_word), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    typedef struct packed {
        logic [9:0] word;
        int         len;
        logic       rd;
        logic [7:0] rsp;
    } exp_t;

    typedef struct packed {
        logic [9:0] word;
        int         len;
        int         gap;
        logic       start_bit;
        logic       mosi_err;
        logic       rsp_seen;
        logic [7:0] rsp;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   checks = 0;
    int   failures = 0;
    int   rsp_count = 0;

    // Slave side: tiny address/data RAM driven by completed frames.
    logic [7:0] ram [256];
    logic [7:0] s_addr = '0;
    logic [7:0] s_rd_addr = '0;
    logic [9:0] s_rx_word = '0;
    int         low_cnt = 0;
    int         high_cnt = 0;
    logic       in_frame = 1'b0;
    logic [9:0] sh = '0;
    logic [7:0] rbyte;
    obs_t       cur;

    initial for (int i = 0; i < 256; i++) ram[i] = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            low_cnt  = 0;
            high_cnt = 0;
            MISO     = 1'b0;
        end else begin
            if (rsp_valid) rsp_count++;
            if (!SS_n) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    low_cnt  = 0;
                    sh       = '0;
                    cur      = '0;
                    cur.gap  = high_cnt;
                end
                if (low_cnt == 0) cur.start_bit = MOSI;
                else if (low_cnt <= CMD_W) sh = {sh[8:0], MOSI};
                else if (MOSI !== 1'b0) cur.mosi_err = 1'b1;
                rbyte = ram[s_rd_addr];
                if (low_cnt >= CMD_W + 1 + TURN && low_cnt < RD_LEN && sh[9:8] == OP_RD_DATA)
                    MISO = rbyte[3'(RD_LEN - 1 - low_cnt)];
                else
                    MISO = 1'b0;
                low_cnt++;
            end else begin
                MISO = 1'b0;
                if (in_frame) begin
                    in_frame     = 1'b0;
                    cur.word     = sh;
                    cur.len      = low_cnt;
                    cur.rsp_seen = rsp_valid;
                    cur.rsp      = rsp_data;
                    if (MOSI !== 1'b0) cur.mosi_err = 1'b1;
                    obs_q.push_back(cur);
                    s_rx_word = sh;
                    case (sh[9:8])
                        OP_WR_ADDR: s_addr = sh[7:0];
                        OP_WR_DATA: ram[s_addr] = sh[7:0];
                        OP_RD_ADDR: s_rd_addr = sh[7:0];
                        default: ;
                    endcase
                    high_cnt = 0;
                end
                high_cnt++;
            end
        end
    end

    task automatic push_exp(input logic [9:0] w, input logic [7:0] rsp);
        exp_t e;
        e.word = w;
        e.rd   = (w[9:8] == OP_RD_DATA);
        e.len  = e.rd ? RD_LEN : WR_LEN;
        e.rsp  = rsp;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(output logic ok);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = cmd_ready;
    endtask

    // One accepted command; returns on the negedge of the START cycle.
    task automatic send_cmd(input logic [9:0] w, input logic [7:0] rsp, input string name);
        logic ok;
        @(negedge clk);
        wait_ready(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_accept cmd_ready=%b required=1", name, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_word  = w;
        push_exp(w, rsp);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, output logic ok);
        int c = 0;
        while (obs_q.size() < n && c < 500) begin
            @(negedge clk);
            c++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL reset_ss_n got=%b required=1", SS_n); end
        checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b required=0", MOSI); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b required=0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h required=00", rsp_data); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b required=0", cmd_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL release_cmd_ready got=%b required=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL release_busy got=%b required=0", busy); end
    endtask

    task automatic test_write_addr();
        logic ok;
        exp_t e;
        obs_t o;
        int   r0 = rsp_count;
        send_cmd(10'h03C, 8'h00, "wr_addr");
        wait_frames(1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wr_addr_timeout frames=%0d required=1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o.word !== e.word || o.start_bit !== e.word[9]) begin failures++; $display("FAIL wr_addr_mosi got=%h/%b required=%h/%b", o.word, o.start_bit, e.word, e.word[9]); end
            checks++; if (o.len !== e.len) begin failures++; $display("FAIL wr_addr_ss_len got=%0d required=%0d", o.len, e.len); end
            checks++; if (o.rsp_seen !== 1'b0 || o.mosi_err !== 1'b0) begin failures++; $display("FAIL wr_addr_flags rsp=%b mosi_err=%b required=0/0", o.rsp_seen, o.mosi_err); end
        end
        checks++; if (s_rx_word !== 10'h03C) begin failures++; $display("FAIL wr_addr_slave_rx got=%h required=03C", s_rx_word); end
        checks++; if (rsp_count !== r0) begin failures++; $display("FAIL wr_addr_rsp_count got=%0d required=%0d", rsp_count, r0); end
    endtask

    task automatic test_read_data();
        logic ok;
        exp_t e;
        obs_t o;
        int   r0 = rsp_count;
        send_cmd(10'h1A5, 8'h00, "rd_setup_wd");
        send_cmd(10'h23C, 8'h00, "rd_setup_ra");
        send_cmd(10'h300, 8'hA5, "rd_data");
        wait_frames(3, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rd_timeout frames=%0d required=3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++; if (o.word !== e.word || o.len !== e.len || o.start_bit !== e.word[9]) begin failures++; $display("FAIL rd_frame%0d got=%h/%0d required=%h/%0d", i, o.word, o.len, e.word, e.len); end
                checks++; if (o.rsp_seen !== e.rd || o.mosi_err !== 1'b0) begin failures++; $display("FAIL rd_flags%0d rsp=%b mosi_err=%b required=%b/0", i, o.rsp_seen, o.mosi_err, e.rd); end
                if (e.rd) begin
                    checks++; if (o.rsp !== e.rsp) begin failures++; $display("FAIL rd_rsp_data got=%h required=%h", o.rsp, e.rsp); end
                end
            end
        end
        repeat (5) @(negedge clk);
        checks++; if (rsp_data !== 8'hA5) begin failures++; $display("FAIL rd_rsp_hold got=%h required=a5", rsp_data); end
        checks++; if (rsp_count !== r0 + 1) begin failures++; $display("FAIL rd_rsp_count got=%0d required=%0d", rsp_count, r0 + 1); end
    endtask

    task automatic test_busy_ignore();
        logic ok;
        exp_t e;
        obs_t o;
        send_cmd(10'h012, 8'h00, "busy_first");
        cmd_valid = 1'b1;
        cmd_word  = 10'h1FF;
        push_exp(10'h1FF, 8'h00);
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL busy_mid busy=%b cmd_ready=%b required=1/0", busy, cmd_ready); end
        wait_ready(ok);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_frames(2, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL busy_timeout frames=%0d required=2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++; if (o.word !== e.word || o.len !== e.len) begin failures++; $display("FAIL busy_frame%0d got=%h/%0d required=%h/%0d", i, o.word, o.len, e.word, e.len); end
            end
        end
        repeat (40) @(negedge clk);
        checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL busy_extra_frames got=%0d required=0", obs_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        logic ok;
        exp_t e;
        obs_t o;
        int   r0 = rsp_count;
        send_cmd(10'h300, 8'hA5, "abort");
        void'(exp_q.pop_back());
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (SS_n !== 1'b1 || MOSI !== 1'b0) begin failures++; $display("FAIL abort_lines ss_n=%b mosi=%b required=1/0", SS_n, MOSI); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b0) begin failures++; $display("FAIL abort_status busy=%b cmd_ready=%b required=0/0", busy, cmd_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (rsp_count !== r0 || obs_q.size() !== 0) begin failures++; $display("FAIL abort_residue rsp=%0d frames=%0d required=%0d/0", rsp_count, obs_q.size(), r0); end
        send_cmd(10'h300, 8'hA5, "after_abort");
        wait_frames(1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL after_abort_timeout frames=%0d required=1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o.word !== e.word || o.len !== e.len) begin failures++; $display("FAIL after_abort_frame got=%h/%0d required=%h/%0d", o.word, o.len, e.word, e.len); end
            checks++; if (o.rsp_seen !== 1'b1 || o.rsp !== e.rsp) begin failures++; $display("FAIL after_abort_rsp got=%b/%h required=1/%h", o.rsp_seen, o.rsp, e.rsp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] words [4];
        logic [7:0] rsps [4];
        logic ok;
        exp_t e;
        obs_t o;
        int   r0 = rsp_count;
        words = '{10'h055, 10'h1C3, 10'h255, 10'h300};
        rsps  = '{8'h00, 8'h00, 8'h00, 8'hC3};
        @(negedge clk);
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_word = words[i];
            push_exp(words[i], rsps[i]);
            wait_ready(ok);
            checks++; if (!ok) begin failures++; $display("FAIL b2b_accept%0d cmd_ready=%b required=1", i, cmd_ready); end
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_frames(4, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_timeout frames=%0d required=4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++; if (o.word !== e.word || o.len !== e.len || o.start_bit !== e.word[9]) begin failures++; $display("FAIL b2b_frame%0d got=%h/%0d required=%h/%0d", i, o.word, o.len, e.word, e.len); end
                if (i > 0) begin
                    checks++; if (o.gap !== GAP + 1) begin failures++; $display("FAIL b2b_gap%0d got=%0d required=%0d", i, o.gap, GAP + 1); end
                end
                checks++; if (o.rsp_seen !== e.rd || (e.rd && o.rsp !== e.rsp)) begin failures++; $display("FAIL b2b_rsp%0d got=%b/%h required=%b/%h", i, o.rsp_seen, o.rsp, e.rd, e.rsp); end
            end
        end
        checks++; if (rsp_count !== r0 + 1) begin failures++; $display("FAIL b2b_rsp_count got=%0d required=%0d", rsp_count, r0 + 1); end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_read_data();
        test_busy_ignore();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time_limit reached");
        $fatal(1, "watchdog");
    end

endmodule
